sprite_palette_bank: RTL and testbench

- Writable, multi-bank sprite palette with a pipelined lookup path.
- Maps a pixel colour index to RGB. Per-entry palettes are loaded at run time, with frame-synchronous bank switching, transparency-key detection and a global brightness fade.
- Sits between the sprite/background ROM readers and the VGA colour mux. Replaces fixed per-sprite constant palettes.

---
 rtl/sprite_palette_bank.sv | 138 +++++++++++++
 tb/tb_sprite_palette_bank.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_palette_bank.sv
// rtl/sprite_palette_bank.sv - multi-bank writable sprite palette with 2-stage faded lookup
module sprite_palette_bank #(
    parameter int                       INDEX_W           = 4,
    parameter int                       BANKS             = 4,
    parameter int                       COLOR_W           = 4,
    parameter int                       TRANSPARENT_INDEX = 0,
    parameter logic [3*COLOR_W-1:0]     KEY_COLOR         = 12'hF0D,
    localparam int                      BANK_W            = $clog2(BANKS)
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    in_valid,
    input  logic [INDEX_W-1:0]      in_index,
    input  logic                    wr_en,
    input  logic [BANK_W-1:0]       wr_bank,
    input  logic [INDEX_W-1:0]      wr_index,
    input  logic [3*COLOR_W-1:0]    wr_color,
    input  logic                    bank_load,
    input  logic [BANK_W-1:0]       bank_next,
    input  logic                    frame_start,
    input  logic [COLOR_W:0]        fade_scale,
    output logic [BANK_W-1:0]       active_bank,
    output logic                    out_valid,
    output logic                    transparent,
    output logic [COLOR_W-1:0]      red,
    output logic [COLOR_W-1:0]      green,
    output logic [COLOR_W-1:0]      blue
);

    localparam int DEPTH   = 2 ** INDEX_W;
    localparam int ENTRY_W = 3 * COLOR_W;
    localparam logic [COLOR_W:0] SCALE_MAX = (COLOR_W + 1)'(2 ** COLOR_W);

    logic [ENTRY_W-1:0] mem_q [BANKS][DEPTH];

    logic [BANK_W-1:0]  active_q, active_d;
    logic [BANK_W-1:0]  pend_bank_q, pend_bank_d;
    logic               pend_valid_q, pend_valid_d;

    logic               v1_q, t1_q;
    logic [ENTRY_W-1:0] c1_q;

    logic               v2_q, t2_q;
    logic [COLOR_W-1:0] r2_q, g2_q, b2_q;
    logic [COLOR_W-1:0] r2_d, g2_d, b2_d;
    logic [COLOR_W:0]   scale_eff;

    function automatic logic [COLOR_W-1:0] fade_ch(
        input logic [COLOR_W-1:0] ch,
        input logic [COLOR_W:0]   s
    );
        return COLOR_W'(({{(COLOR_W+1){1'b0}}, ch} * {{COLOR_W{1'b0}}, s}) >> COLOR_W);
    endfunction

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int b = 0; b < BANKS; b++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem_q[b][i] <= (i == TRANSPARENT_INDEX) ? KEY_COLOR : '0;
                end
            end
        end else if (wr_en) begin
            mem_q[wr_bank][wr_index] <= wr_color;
        end
    end

    // A same-edge load+frame_start bypasses the pending slot entirely.
    always_comb begin
        active_d     = active_q;
        pend_bank_d  = pend_bank_q;
        pend_valid_d = pend_valid_q;
        if (frame_start && bank_load) begin
            active_d     = bank_next;
            pend_valid_d = 1'b0;
        end else if (frame_start && pend_valid_q) begin
            active_d     = pend_bank_q;
            pend_valid_d = 1'b0;
        end else if (bank_load) begin
            pend_bank_d  = bank_next;
            pend_valid_d = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            active_q     <= '0;
            pend_bank_q  <= '0;
            pend_valid_q <= 1'b0;
        end else begin
            active_q     <= active_d;
            pend_bank_q  <= pend_bank_d;
            pend_valid_q <= pend_valid_d;
        end
    end

    always_comb begin
        scale_eff = (fade_scale > SCALE_MAX) ? SCALE_MAX : fade_scale;
        r2_d      = '0;
        g2_d      = '0;
        b2_d      = '0;
        if (!t1_q) begin
            r2_d = fade_ch(c1_q[3*COLOR_W-1:2*COLOR_W], scale_eff);
            g2_d = fade_ch(c1_q[2*COLOR_W-1:COLOR_W], scale_eff);
            b2_d = fade_ch(c1_q[COLOR_W-1:0], scale_eff);
        end
    end

    // Stage 1 reads the array before this edge's write lands: read-before-write.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            v1_q <= 1'b0;
            t1_q <= 1'b0;
            c1_q <= '0;
            v2_q <= 1'b0;
            t2_q <= 1'b0;
            r2_q <= '0;
            g2_q <= '0;
            b2_q <= '0;
        end else begin
            v1_q <= in_valid;
            t1_q <= (in_index == INDEX_W'(TRANSPARENT_INDEX));
            c1_q <= mem_q[active_q][in_index];
            v2_q <= v1_q;
            t2_q <= t1_q;
            r2_q <= r2_d;
            g2_q <= g2_d;
            b2_q <= b2_d;
        end
    end

    assign active_bank = active_q;
    assign out_valid   = v2_q;
    assign transparent = t2_q;
    assign red         = r2_q;
    assign green       = g2_q;
    assign blue        = b2_q;

endmodule

// File: tb/tb_sprite_palette_bank.sv
// tb/tb_sprite_palette_bank.sv - scoreboard bench for sprite_palette_bank
module tb_sprite_palette_bank;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  in_index = '0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_bank = '0;
    logic [3:0]  wr_index = '0;
    logic [11:0] wr_color = '0;
    logic        bank_load = 1'b0;
    logic [1:0]  bank_next = '0;
    logic        frame_start = 1'b0;
    logic [4:0]  fade_scale = 5'd16;
    logic [1:0]  active_bank;
    logic        out_valid, transparent;
    logic [3:0]  red, green, blue;

    sprite_palette_bank dut (
        .Clk(Clk), .Reset_n(Reset_n), .in_valid(in_valid), .in_index(in_index),
        .wr_en(wr_en), .wr_bank(wr_bank), .wr_index(wr_index), .wr_color(wr_color),
        .bank_load(bank_load), .bank_next(bank_next), .frame_start(frame_start),
        .fade_scale(fade_scale), .active_bank(active_bank), .out_valid(out_valid),
        .transparent(transparent), .red(red), .green(green), .blue(blue)
    );

    always #5 Clk = ~Clk;

    typedef struct { int due; logic t; logic [11:0] rgb; } exp_t;
    exp_t exp_q[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int nout = 0;
    int ntrans = 0;
    logic        last_t = 1'b0;
    logic [11:0] last_rgb = '0;

    logic [11:0] m_mem [4][16];
    int   m_active, m_pbank;
    bit   m_pv;
    bit   p_req, p_t;
    logic [11:0] p_col;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, want, $time);
        end
    endtask

    function automatic int fade(input int c, input int f);
        int s;
        s = (f > 16) ? 16 : f;
        return (c * s) / 16;
    endfunction

    // Reference: palette as an array, active bank as an integer, fade by plain arithmetic.
    always @(posedge Clk or negedge Reset_n) begin
        exp_t e;
        if (!Reset_n) begin
            for (int b = 0; b < 4; b++)
                for (int i = 0; i < 16; i++)
                    m_mem[b][i] = (i == 0) ? 12'hF0D : 12'h000;
            m_active = 0; m_pbank = 0; m_pv = 0; p_req = 0;
            exp_q.delete();
        end else begin
            cyc++;
            if (p_req) begin
                e.due = cyc;
                e.t   = p_t;
                if (p_t) e.rgb = 12'h000;
                else e.rgb = {4'(fade(p_col[11:8], fade_scale)), 4'(fade(p_col[7:4], fade_scale)),
                              4'(fade(p_col[3:0], fade_scale))};
                exp_q.push_back(e);
            end
            p_req = in_valid;
            p_col = m_mem[m_active][in_index];
            p_t   = (in_index == 4'd0);
            if (wr_en) m_mem[wr_bank][wr_index] = wr_color;
            if (bank_load && frame_start) begin
                m_active = int'(bank_next); m_pv = 0;
            end else if (frame_start && m_pv) begin
                m_active = m_pbank; m_pv = 0;
            end else if (bank_load) begin
                m_pbank = int'(bank_next); m_pv = 1;
            end
        end
    end

    always @(negedge Clk) begin
        if (Reset_n) begin
            chk("active_bank", 32'(active_bank), 32'(m_active));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    chk("latency", cyc, exp_q[0].due);
                    chk("transparent", 32'(transparent), 32'(exp_q[0].t));
                    chk("rgb", 32'({red, green, blue}), 32'(exp_q[0].rgb));
                    exp_q.delete(0);
                end
                last_t = transparent;
                last_rgb = {red, green, blue};
                nout++;
                if (transparent) ntrans++;
            end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                chk("missing_out", 0, 1);
                exp_q.delete(0);
            end
        end
    end

    task automatic step();
        @(negedge Clk);
        in_valid = 0; wr_en = 0; bank_load = 0; frame_start = 0;
    endtask

    task automatic req(input int idx);
        in_valid = 1; in_index = 4'(idx);
    endtask

    task automatic wr(input int b, input int idx, input logic [11:0] c);
        wr_en = 1; wr_bank = 2'(b); wr_index = 4'(idx); wr_color = c;
    endtask

    initial begin
        int n0, t0;
        repeat (3) @(negedge Clk);
        Reset_n = 1;
        chk("rst_active", 32'(active_bank), 0);
        chk("rst_valid", 32'(out_valid), 0);

        req(0); step(); req(5); step(); #1;
        chk("rst_idx0_t", 32'(last_t), 1);
        chk("rst_idx0_rgb", 32'(last_rgb), 0);
        step(); #1;
        chk("rst_idx5_t", 32'(last_t), 0);
        chk("rst_idx5_rgb", 32'(last_rgb), 0);

        wr(0, 3, 12'h9A3); step();
        req(3); step(); step(); #1;
        chk("wr_read", 32'(last_rgb), 32'h9A3);
        wr(0, 3, 12'h123); req(3); step();
        req(3); step(); #1;
        chk("collision_old", 32'(last_rgb), 32'h9A3);
        step(); #1;
        chk("collision_new", 32'(last_rgb), 32'h123);

        wr(0, 4, 12'hF84); step();
        fade_scale = 8;  req(4); step(); step(); #1;
        chk("fade8", 32'(last_rgb), 32'h742);
        fade_scale = 0;  req(4); step(); step(); #1;
        chk("fade0", 32'(last_rgb), 32'h000);
        fade_scale = 31; req(4); step(); step(); #1;
        chk("fade31", 32'(last_rgb), 32'hF84);
        fade_scale = 16;

        wr(0, 2, 12'h111); step();
        wr(1, 2, 12'hEEE); step();
        bank_load = 1; bank_next = 1; step();
        req(2); step(); step(); #1;
        chk("pending_no_effect", 32'(last_rgb), 32'h111);
        req(2); step();
        req(2); frame_start = 1; step(); #1;
        chk("switch_active", 32'(active_bank), 1);
        chk("pre_first", 32'(last_rgb), 32'h111);
        req(2); step(); #1;
        chk("pre_last", 32'(last_rgb), 32'h111);
        step(); #1;
        chk("post_first", 32'(last_rgb), 32'hEEE);
        bank_load = 1; bank_next = 2; frame_start = 1; step(); #1;
        chk("direct_switch", 32'(active_bank), 2);
        bank_load = 1; bank_next = 0; frame_start = 1; step();

        n0 = nout; t0 = ntrans;
        for (int i = 0; i < 16; i++) begin
            req(i); step();
        end
        step(); step(); #1;
        chk("stream_count", nout - n0, 16);
        chk("stream_transparent", ntrans - t0, 1);

        for (int k = 0; k < 400; k++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            in_index    = 4'($urandom_range(0, 15));
            wr_en       = ($urandom_range(0, 2) == 0);
            wr_bank     = 2'($urandom_range(0, 3));
            wr_index    = 4'($urandom_range(0, 15));
            wr_color    = 12'($urandom);
            bank_load   = ($urandom_range(0, 9) == 0);
            bank_next   = 2'($urandom_range(0, 3));
            frame_start = ($urandom_range(0, 14) == 0);
            fade_scale  = 5'($urandom_range(0, 31));
            step();
        end
        fade_scale = 16;
        step(); step(); step();

        req(3); step();
        req(3); @(posedge Clk); #2;
        Reset_n = 0; in_valid = 0; #1;
        chk("async_valid", 32'(out_valid), 0);
        chk("async_rgb", 32'({red, green, blue}), 0);
        chk("async_active", 32'(active_bank), 0);
        @(negedge Clk); Reset_n = 1;
        req(3); step(); step(); #1;
        chk("post_rst_entry", 32'(last_rgb), 0);
        chk("post_rst_entry_t", 32'(last_t), 0);
        req(0); step(); step(); #1;
        chk("post_rst_idx0_t", 32'(last_t), 1);
        step(); step();
        chk("drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
